// File: rtl/write_data_pkg.sv
// Shared definitions for the BMP pixel-stream sink: state encodings, BMP constants, pixel pair packing.
// WRITE_HEADER_EN selects whether the 54-byte BMP header precedes the pixel data.
package write_data_pkg;

    localparam int unsigned BMP_HDR_BYTES   = 54;
    localparam int unsigned BYTES_PER_PIXEL = 3;
    localparam int unsigned WORD_BYTES      = 6;
    localparam int unsigned HDR_WORDS       = BMP_HDR_BYTES / WORD_BYTES;
    localparam int unsigned DATA_W          = 48;

`ifdef WRITE_HEADER_EN
    localparam int unsigned HDR_OFFSET = BMP_HDR_BYTES;
`else
    localparam int unsigned HDR_OFFSET = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_ARMED  = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // BMP stores each pixel as B,G,R; even pixel occupies the lower address
    function automatic logic [DATA_W-1:0] pack_pair(input rgb_t even, input rgb_t odd);
        return {odd.r, odd.g, odd.b, even.r, even.g, even.b};
    endfunction

endpackage

// File: rtl/write_data_bmp_header_rom.sv
// BMP header as nine 48-bit little-endian words, selected combinationally by word index.
// Present only when WRITE_HEADER_EN is defined.
`ifdef WRITE_HEADER_EN
module bmp_header_rom
    import write_data_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = 768,
    parameter int unsigned IMAGE_HEIGHT = 512
) (
    input  logic [3:0]        idx,
    output logic [DATA_W-1:0] word_c
);

    localparam int unsigned IMG_BYTES  = IMAGE_WIDTH * IMAGE_HEIGHT * BYTES_PER_PIXEL;
    localparam int unsigned FILE_BYTES = BMP_HDR_BYTES + IMG_BYTES;

    // Fields listed from the highest byte offset down so byte 0 lands in bits [7:0]
    localparam logic [HDR_WORDS*DATA_W-1:0] HDR_IMAGE = {
        32'd0,                  // important colours
        32'd0,                  // palette colours
        32'd0,                  // y pixels per metre
        32'd0,                  // x pixels per metre
        32'(IMG_BYTES),
        32'd0,                  // compression
        16'd24,                 // bits per pixel
        16'd1,                  // planes
        32'(IMAGE_HEIGHT),
        32'(IMAGE_WIDTH),
        32'd40,                 // DIB header size
        32'(BMP_HDR_BYTES),     // pixel data offset
        32'd0,                  // reserved
        32'(FILE_BYTES),
        8'h4D,
        8'h42
    };

    always_comb begin
        word_c = '0;
        for (int unsigned k = 0; k < HDR_WORDS; k++) begin
            if (idx == 4'(k)) word_c = HDR_IMAGE[k*DATA_W +: DATA_W];
        end
    end

endmodule
`endif

// File: rtl/write_data.sv
// Pixel-pair sink: converts even/odd RGB pairs to bottom-up 24-bit BMP order and issues 48-bit writes.
// WRITE_HEADER_EN adds a HEADER state that writes the 54-byte BMP header before the pixels.
module write_data
    import write_data_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = 768,
    parameter int unsigned IMAGE_HEIGHT = 512,
    parameter int unsigned ADDR_WIDTH   = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vertical_Pulse,
    input  logic                  horizontal_Pulse,
    input  logic [7:0]            data_R_Even,
    input  logic [7:0]            data_G_Even,
    input  logic [7:0]            data_B_Even,
    input  logic [7:0]            data_R_Odd,
    input  logic [7:0]            data_G_Odd,
    input  logic [7:0]            data_B_Odd,
    output logic                  wr_En,
    output logic [ADDR_WIDTH-1:0] wr_Addr,
    output logic [DATA_W-1:0]     wr_Data,
    output logic                  done_Flag,
    output logic                  frame_Error
);

    localparam int unsigned COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int unsigned ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    rgb_t                  even_c, odd_c;
    logic                  last_col_c, last_row_c;
    logic [ADDR_WIDTH-1:0] pix_addr_c;

`ifdef WRITE_HEADER_EN
    logic [3:0]            hdr_idx_q, hdr_idx_d;
    logic [DATA_W-1:0]     hdr_word_c;

    bmp_header_rom #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT)
    ) u_hdr_rom (
        .idx    (hdr_idx_q),
        .word_c (hdr_word_c)
    );
`endif

    assign even_c     = '{r: data_R_Even, g: data_G_Even, b: data_B_Even};
    assign odd_c      = '{r: data_R_Odd,  g: data_G_Odd,  b: data_B_Odd};
    assign last_col_c = (col_q == COL_W'(IMAGE_WIDTH - 2));
    assign last_row_c = (row_q == ROW_W'(IMAGE_HEIGHT - 1));

    // Row 0 of the stream is the top image row, which BMP stores last
    assign pix_addr_c = ADDR_WIDTH'(HDR_OFFSET)
                      + ((ADDR_WIDTH'(IMAGE_HEIGHT - 1) - ADDR_WIDTH'(row_q)) * ADDR_WIDTH'(IMAGE_WIDTH)
                         + ADDR_WIDTH'(col_q)) * ADDR_WIDTH'(BYTES_PER_PIXEL);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        err_d     = err_q;
`ifdef WRITE_HEADER_EN
        hdr_idx_d = hdr_idx_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (horizontal_Pulse) err_d = 1'b1;
                if (vertical_Pulse) begin
`ifdef WRITE_HEADER_EN
                    state_d   = ST_HEADER;
                    hdr_idx_d = '0;
`else
                    state_d   = ST_ARMED;
`endif
                end
            end
`ifdef WRITE_HEADER_EN
            ST_HEADER: begin
                if (horizontal_Pulse) err_d = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_WIDTH'(32'(hdr_idx_q) * WORD_BYTES);
                wr_data_d = hdr_word_c;
                if (hdr_idx_q == 4'(HDR_WORDS - 1)) state_d = ST_ARMED;
                else                                hdr_idx_d = hdr_idx_q + 4'd1;
            end
`endif
            ST_ARMED, ST_DATA: begin
                if (state_q == ST_DATA && vertical_Pulse) err_d = 1'b1;
                if (horizontal_Pulse) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_addr_c;
                    wr_data_d = pack_pair(even_c, odd_c);
                    state_d   = ST_DATA;
                    if (last_col_c) begin
                        col_d = '0;
                        if (last_row_c) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(2);
                    end
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef WRITE_HEADER_EN
            hdr_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef WRITE_HEADER_EN
            hdr_idx_q <= hdr_idx_d;
`endif
        end
    end

    assign wr_En       = wr_en_q;
    assign wr_Addr     = wr_addr_q;
    assign wr_Data     = wr_data_q;
    assign done_Flag   = done_q;
    assign frame_Error = err_q;

endmodule
